control_unit_pipe: RTL and testbench
====================================

Name: control_unit_pipe

Overview:
- Pipelined successor to the single-cycle RV32I control unit.
- Decodes op/funct3/funct7_5 in the Decode stage and carries the control bundle through the Execute, Memory and Writeback pipeline registers.
- Each pipeline register supports stall and flush.
- Resolves branch/jump redirection (PCSrc_e) in Execute from ALU flags, covering all six RV32I branch conditions.

Parameters:
- OP_WIDTH, 7, opcode width.
- FUNCT3_WIDTH, 3, funct3 width.
- ALU_CTRL_WIDTH, 4, ALUControl width.
- IMM_SRC_WIDTH, 3, ImmSrc width.
- RESULT_SRC_WIDTH, 2, ResultSrc width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- op_d  input  OP_WIDTH  opcode of the instruction in Decode.
- funct3_d  input  FUNCT3_WIDTH  funct3 in Decode.
- funct7_5_d  input  1  instr[30] in Decode.
- stall_e  input  1  hold the E register; M receives a bubble.
- flush_e  input  1  load a bubble into the E register.
- zero_e, lt_e, ltu_e  input  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- ImmSrc_d  output  IMM_SRC_WIDTH  combinational, drives the immediate extender.
- illegal_d  output  1  combinational, opcode is not a legal RV32I opcode.
- ALUControl_e  output  ALU_CTRL_WIDTH  registered.
- ALUSrc_e  output  1  registered, 1 selects immediate as ALU operand B.
- ALUSrcA_e  output  1  registered, 1 selects PC as ALU operand A (auipc).
- ResultSrc_e  output  RESULT_SRC_WIDTH  registered, for load-use hazard detection.
- RegWrite_e  output  1  registered.
- PCSrc_e  output  1  combinational from E-stage state, 1 = redirect fetch.
- JumpReg_e  output  1  registered, jalr target = rs1 + imm.
- RegWrite_m, MemWrite_m  output  1 each  registered.
- ResultSrc_m  output  RESULT_SRC_WIDTH  registered.
- RegWrite_w  output  1  registered.
- ResultSrc_w  output  RESULT_SRC_WIDTH  registered.
- illegal_w  output  1  registered, illegal instruction has reached Writeback.

Behaviour:
- Encodings:
  - ImmSrc: I=000, S=001, B=010, J=011, U=100.
  - ResultSrc: ALU=00, mem=01, PC+4=10, imm=11.
  - ALUControl: add=0000, sub=0001, and=0010, or=0011, xor=0100, slt=0101, sltu=0110, sll=0111, srl=1000, sra=1001.
- Decode table:
  - R (0110011): RegWrite=1. funct7_5 selects sub (funct3 000) and sra (funct3 101).
  - I-ALU (0010011): ALUSrc=1, RegWrite=1. funct7_5 is honoured only for funct3 101 (srai), so addi with instr[30]=1 decodes as add.
  - load (0000011): ALUSrc=1, RegWrite=1, ResultSrc=01, add.
  - store (0100011): ALUSrc=1, MemWrite=1, ImmSrc=S, add.
  - branch (1100011): Branch=1, ImmSrc=B, sub.
  - jal (1101111): Jump=1, RegWrite=1, ResultSrc=10, ImmSrc=J.
  - jalr (1100111): Jump=1, JumpReg=1, ALUSrc=1, RegWrite=1, ResultSrc=10, add.
  - lui (0110111): RegWrite=1, ResultSrc=11, ImmSrc=U.
  - auipc (0010111): ALUSrcA=1, ALUSrc=1, RegWrite=1, ImmSrc=U, add.
- Illegal opcodes:
  - Any other opcode asserts illegal_d, with all enables 0 and other fields 0.
  - illegal_d travels in the bundle to illegal_w.
- Bubble: the all-zero bundle.
- E register, each rising clk, in priority order:
  - !rst_n: bubble.
  - else flush_e: bubble.
  - else stall_e: hold.
  - else load the decoded bundle.
- E register also captures funct3_d, Branch and Jump.
- M register:
  - Loads a bubble on !rst_n, and also when stall_e=1 and flush_e=0.
  - Otherwise loads the E bundle.
- W register: bubble on !rst_n, otherwise loads the M bundle.
- Simultaneous flush_e and stall_e: flush wins, and M still loads the E bundle (the instruction ahead proceeds).
- PCSrc_e = Jump_e | (Branch_e & taken). taken by funct3_e:
  - 000: zero.
  - 001: !zero.
  - 100: lt.
  - 101: !lt.
  - 110: ltu.
  - 111: !ltu.
  - 010 or 011: 0.
- PCSrc_e is forced to 0 whenever the E bundle is a bubble.
- Latency: decode to E outputs is 1 cycle, to M is 2, to W is 3.
- Reset: every registered output and PCSrc_e read 0 in the cycle after rst_n is sampled low. Reset mid-stream discards all in-flight bundles.

Test Plan:
- Reset then add (R, funct3 000, funct7_5=0) then NOPs:
  - Cycle+1: ALUControl_e=0000, RegWrite_e=1.
  - Cycle+2: RegWrite_m=1.
  - Cycle+3: RegWrite_w=1, ResultSrc_w=00.
- beq (funct3 000):
  - zero_e=1 -> PCSrc_e=1.
  - bge (101) with lt_e=1 -> PCSrc_e=0.
  - bltu (110) with ltu_e=1 -> PCSrc_e=1.
  - funct3 010 -> PCSrc_e=0.
- lw then stall_e=1 for 2 cycles:
  - ResultSrc_e holds 01 throughout.
  - RegWrite_m=0 on both stalled cycles.
  - Released: ResultSrc_m=01.
- jal with flush_e=1 in the same cycle:
  - E becomes bubble, PCSrc_e=0, RegWrite_e=0.
  - With stall_e=1 also asserted: flush still wins.
- op_d=1111111 -> illegal_d=1, ImmSrc_d=000; 3 cycles later illegal_w=1, RegWrite_w=0.
- sw, addi with funct7_5=1, srai, lui, auipc decode:
  - sw: MemWrite_m=1, ImmSrc_d=001.
  - addi with funct7_5=1: ALUControl_e=0000.
  - srai: 1001.
  - lui: ResultSrc_e=11.
  - auipc: ALUSrcA_e=1.
- Mid-stream: rst_n=0 for 1 cycle -> all E/M/W outputs 0 in the next cycle.

Source files
------------

// File: rtl/control_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_pipe
//  Description : Pipelined RV32I control unit. Decodes op/funct3/funct7_5 in
//                the Decode stage and carries the resulting control bundle
//                through the Execute, Memory and Writeback pipeline
//                registers. Branch/jump redirection (PCSrc_e) is resolved in
//                Execute from the ALU flags for all six branch conditions.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          clock (rising edge), synchronous active-low reset
//    op_d, funct3_d,     instruction fields in Decode
//    funct7_5_d
//    stall_e, flush_e    Execute-register hold / bubble insertion
//    zero_e, lt_e, ltu_e ALU flags: equal, signed <, unsigned <
//    ImmSrc_d            immediate format for the extender (combinational)
//    illegal_d           opcode is not a legal RV32I opcode (combinational)
//    *_e                 Execute-stage controls (registered)
//    PCSrc_e             redirect fetch (combinational from E state)
//    *_m, *_w            Memory / Writeback controls (registered)
// ============================================================================
module control_unit_pipe #(
    parameter int OP_WIDTH         = 7,
    parameter int FUNCT3_WIDTH     = 3,
    parameter int ALU_CTRL_WIDTH   = 4,
    parameter int IMM_SRC_WIDTH    = 3,
    parameter int RESULT_SRC_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [OP_WIDTH-1:0]         op_d,
    input  logic [FUNCT3_WIDTH-1:0]     funct3_d,
    input  logic                        funct7_5_d,
    input  logic                        stall_e,
    input  logic                        flush_e,
    input  logic                        zero_e,
    input  logic                        lt_e,
    input  logic                        ltu_e,
    output logic [IMM_SRC_WIDTH-1:0]    ImmSrc_d,
    output logic                        illegal_d,
    output logic [ALU_CTRL_WIDTH-1:0]   ALUControl_e,
    output logic                        ALUSrc_e,
    output logic                        ALUSrcA_e,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrc_e,
    output logic                        RegWrite_e,
    output logic                        PCSrc_e,
    output logic                        JumpReg_e,
    output logic                        RegWrite_m,
    output logic                        MemWrite_m,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrc_m,
    output logic                        RegWrite_w,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrc_w,
    output logic                        illegal_w
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [OP_WIDTH-1:0] OP_R      = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_I_ALU  = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(7'b1100111);
    localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(7'b0110111);
    localparam logic [OP_WIDTH-1:0] OP_AUIPC  = OP_WIDTH'(7'b0010111);

    // ------------------------------------------------------------------
    // Field encodings
    // ------------------------------------------------------------------
    localparam logic [IMM_SRC_WIDTH-1:0] IMM_I = IMM_SRC_WIDTH'(3'b000);
    localparam logic [IMM_SRC_WIDTH-1:0] IMM_S = IMM_SRC_WIDTH'(3'b001);
    localparam logic [IMM_SRC_WIDTH-1:0] IMM_B = IMM_SRC_WIDTH'(3'b010);
    localparam logic [IMM_SRC_WIDTH-1:0] IMM_J = IMM_SRC_WIDTH'(3'b011);
    localparam logic [IMM_SRC_WIDTH-1:0] IMM_U = IMM_SRC_WIDTH'(3'b100);

    localparam logic [RESULT_SRC_WIDTH-1:0] RES_ALU = RESULT_SRC_WIDTH'(2'b00);
    localparam logic [RESULT_SRC_WIDTH-1:0] RES_MEM = RESULT_SRC_WIDTH'(2'b01);
    localparam logic [RESULT_SRC_WIDTH-1:0] RES_PC4 = RESULT_SRC_WIDTH'(2'b10);
    localparam logic [RESULT_SRC_WIDTH-1:0] RES_IMM = RESULT_SRC_WIDTH'(2'b11);

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD  = ALU_CTRL_WIDTH'(4'b0000);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB  = ALU_CTRL_WIDTH'(4'b0001);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND  = ALU_CTRL_WIDTH'(4'b0010);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR   = ALU_CTRL_WIDTH'(4'b0011);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR  = ALU_CTRL_WIDTH'(4'b0100);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT  = ALU_CTRL_WIDTH'(4'b0101);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU = ALU_CTRL_WIDTH'(4'b0110);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL  = ALU_CTRL_WIDTH'(4'b0111);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL  = ALU_CTRL_WIDTH'(4'b1000);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA  = ALU_CTRL_WIDTH'(4'b1001);

    // ------------------------------------------------------------------
    // Control bundle carried into Execute. The all-zero value is a bubble.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic                        illegal;
        logic                        reg_write;
        logic                        mem_write;
        logic                        branch;
        logic                        jump;
        logic                        jump_reg;
        logic                        alu_src;
        logic                        alu_src_a;
        logic [RESULT_SRC_WIDTH-1:0] result_src;
        logic [ALU_CTRL_WIDTH-1:0]   alu_ctrl;
        logic [FUNCT3_WIDTH-1:0]     funct3;
    } bundle_t;

    bundle_t                       dec_bundle;
    logic [IMM_SRC_WIDTH-1:0]      dec_imm_src;
    logic [ALU_CTRL_WIDTH-1:0]     alu_arith;
    logic                          alt_sel;

    bundle_t                       e_q;
    logic                          m_reg_write;
    logic                          m_mem_write;
    logic [RESULT_SRC_WIDTH-1:0]   m_result_src;
    logic                          m_illegal;
    logic                          w_reg_write;
    logic [RESULT_SRC_WIDTH-1:0]   w_result_src;
    logic                          w_illegal;
    logic                          br_taken;

    // ------------------------------------------------------------------
    // Arithmetic operation for R-type and I-ALU. instr[30] picks sub only
    // for register-register add; it picks sra for both forms of shift right.
    // This keeps addi with instr[30]=1 decoding as add.
    // ------------------------------------------------------------------
    always_comb begin
        alt_sel = funct7_5_d &
                  (((funct3_d == 3'b000) && (op_d == OP_R)) || (funct3_d == 3'b101));
        alu_arith = ALU_ADD;
        case (funct3_d)
            3'b000:  alu_arith = alt_sel ? ALU_SUB : ALU_ADD;
            3'b001:  alu_arith = ALU_SLL;
            3'b010:  alu_arith = ALU_SLT;
            3'b011:  alu_arith = ALU_SLTU;
            3'b100:  alu_arith = ALU_XOR;
            3'b101:  alu_arith = alt_sel ? ALU_SRA : ALU_SRL;
            3'b110:  alu_arith = ALU_OR;
            3'b111:  alu_arith = ALU_AND;
            default: alu_arith = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Main decoder
    // ------------------------------------------------------------------
    always_comb begin
        dec_bundle  = '0;
        dec_imm_src = IMM_I;
        case (op_d)
            OP_R: begin
                dec_bundle.reg_write = 1'b1;
                dec_bundle.alu_ctrl  = alu_arith;
            end
            OP_I_ALU: begin
                dec_bundle.alu_src   = 1'b1;
                dec_bundle.reg_write = 1'b1;
                dec_bundle.alu_ctrl  = alu_arith;
            end
            OP_LOAD: begin
                dec_bundle.alu_src    = 1'b1;
                dec_bundle.reg_write  = 1'b1;
                dec_bundle.result_src = RES_MEM;
                dec_bundle.alu_ctrl   = ALU_ADD;
            end
            OP_STORE: begin
                dec_bundle.alu_src   = 1'b1;
                dec_bundle.mem_write = 1'b1;
                dec_bundle.alu_ctrl  = ALU_ADD;
                dec_imm_src          = IMM_S;
            end
            OP_BRANCH: begin
                dec_bundle.branch   = 1'b1;
                dec_bundle.alu_ctrl = ALU_SUB;
                dec_imm_src         = IMM_B;
            end
            OP_JAL: begin
                dec_bundle.jump       = 1'b1;
                dec_bundle.reg_write  = 1'b1;
                dec_bundle.result_src = RES_PC4;
                dec_imm_src           = IMM_J;
            end
            OP_JALR: begin
                dec_bundle.jump       = 1'b1;
                dec_bundle.jump_reg   = 1'b1;
                dec_bundle.alu_src    = 1'b1;
                dec_bundle.reg_write  = 1'b1;
                dec_bundle.result_src = RES_PC4;
                dec_bundle.alu_ctrl   = ALU_ADD;
            end
            OP_LUI: begin
                dec_bundle.reg_write  = 1'b1;
                dec_bundle.result_src = RES_IMM;
                dec_imm_src           = IMM_U;
            end
            OP_AUIPC: begin
                dec_bundle.alu_src_a  = 1'b1;
                dec_bundle.alu_src    = 1'b1;
                dec_bundle.reg_write  = 1'b1;
                dec_bundle.result_src = RES_ALU;
                dec_bundle.alu_ctrl   = ALU_ADD;
                dec_imm_src           = IMM_U;
            end
            default: begin
                dec_bundle.illegal = 1'b1;
            end
        endcase
        // An illegal instruction carries nothing but its illegal flag.
        if (!dec_bundle.illegal) begin
            dec_bundle.funct3 = funct3_d;
        end
    end

    assign ImmSrc_d  = dec_imm_src;
    assign illegal_d = dec_bundle.illegal;

    // ------------------------------------------------------------------
    // Execute register: reset, then flush, then stall, then load.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q <= '0;
        end else if (flush_e) begin
            e_q <= '0;
        end else if (!stall_e) begin
            e_q <= dec_bundle;
        end
    end

    // ------------------------------------------------------------------
    // Memory register. While E is held the instruction in E must not also
    // advance, so M takes a bubble. A flush overrides the stall, and then
    // the instruction in E proceeds into M normally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n || (stall_e && !flush_e)) begin
            m_reg_write  <= 1'b0;
            m_mem_write  <= 1'b0;
            m_result_src <= '0;
            m_illegal    <= 1'b0;
        end else begin
            m_reg_write  <= e_q.reg_write;
            m_mem_write  <= e_q.mem_write;
            m_result_src <= e_q.result_src;
            m_illegal    <= e_q.illegal;
        end
    end

    // ------------------------------------------------------------------
    // Writeback register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_reg_write  <= 1'b0;
            w_result_src <= '0;
            w_illegal    <= 1'b0;
        end else begin
            w_reg_write  <= m_reg_write;
            w_result_src <= m_result_src;
            w_illegal    <= m_illegal;
        end
    end

    // ------------------------------------------------------------------
    // Branch resolution. funct3 010/011 are not branch conditions and
    // never redirect. A bubble has branch and jump clear, so PCSrc_e is
    // inherently 0 for it.
    // ------------------------------------------------------------------
    always_comb begin
        br_taken = 1'b0;
        case (e_q.funct3)
            3'b000:  br_taken = zero_e;
            3'b001:  br_taken = !zero_e;
            3'b100:  br_taken = lt_e;
            3'b101:  br_taken = !lt_e;
            3'b110:  br_taken = ltu_e;
            3'b111:  br_taken = !ltu_e;
            default: br_taken = 1'b0;
        endcase
    end

    assign PCSrc_e      = e_q.jump | (e_q.branch & br_taken);

    assign ALUControl_e = e_q.alu_ctrl;
    assign ALUSrc_e     = e_q.alu_src;
    assign ALUSrcA_e    = e_q.alu_src_a;
    assign ResultSrc_e  = e_q.result_src;
    assign RegWrite_e   = e_q.reg_write;
    assign JumpReg_e    = e_q.jump_reg;

    assign RegWrite_m   = m_reg_write;
    assign MemWrite_m   = m_mem_write;
    assign ResultSrc_m  = m_result_src;

    assign RegWrite_w   = w_reg_write;
    assign ResultSrc_w  = w_result_src;
    assign illegal_w    = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_control_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit_pipe
//  Description : Self-checking bench for control_unit_pipe. Directed
//                scenarios followed by randomized instruction streams with
//                random stall/flush/reset, compared every cycle against a
//                behavioural pipeline model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op_d;
    logic [2:0] funct3_d;
    logic       funct7_5_d;
    logic       stall_e, flush_e, zero_e, lt_e, ltu_e;
    logic [2:0] ImmSrc_d;
    logic       illegal_d;
    logic [3:0] ALUControl_e;
    logic       ALUSrc_e, ALUSrcA_e, RegWrite_e, PCSrc_e, JumpReg_e;
    logic [1:0] ResultSrc_e;
    logic       RegWrite_m, MemWrite_m;
    logic [1:0] ResultSrc_m;
    logic       RegWrite_w;
    logic [1:0] ResultSrc_w;
    logic       illegal_w;

    control_unit_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_d         (op_d),
        .funct3_d     (funct3_d),
        .funct7_5_d   (funct7_5_d),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .zero_e       (zero_e),
        .lt_e         (lt_e),
        .ltu_e        (ltu_e),
        .ImmSrc_d     (ImmSrc_d),
        .illegal_d    (illegal_d),
        .ALUControl_e (ALUControl_e),
        .ALUSrc_e     (ALUSrc_e),
        .ALUSrcA_e    (ALUSrcA_e),
        .ResultSrc_e  (ResultSrc_e),
        .RegWrite_e   (RegWrite_e),
        .PCSrc_e      (PCSrc_e),
        .JumpReg_e    (JumpReg_e),
        .RegWrite_m   (RegWrite_m),
        .MemWrite_m   (MemWrite_m),
        .ResultSrc_m  (ResultSrc_m),
        .RegWrite_w   (RegWrite_w),
        .ResultSrc_w  (ResultSrc_w),
        .illegal_w    (illegal_w)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Expected content of one pipeline slot.
    typedef struct packed {
        logic       rw, mw, br, jp, jr, as, asa, ill;
        logic [1:0] rs;
        logic [3:0] alu;
        logic [2:0] imm;
        logic [2:0] f3;
    } ctl_t;

    ctl_t mdl_e = '0, mdl_m = '0, mdl_w = '0;
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ALU operation from the RV32I funct3 table; alt = instr[30] takes effect.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd9;
        return tbl[f3];
    endfunction

    function automatic ctl_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        ctl_t c;
        c = '0;
        c.f3 = f3;
        case (op)
            OP_R:     begin c.rw = 1; c.alu = alu_of(f3, f75); end
            OP_I:     begin c.rw = 1; c.as = 1; c.alu = alu_of(f3, f75 && f3 == 3'd5); end
            OP_LOAD:  begin c.rw = 1; c.as = 1; c.rs = 2'b01; end
            OP_STORE: begin c.mw = 1; c.as = 1; c.imm = 3'b001; end
            OP_BR:    begin c.br = 1; c.imm = 3'b010; c.alu = 4'd1; end
            OP_JAL:   begin c.jp = 1; c.rw = 1; c.rs = 2'b10; c.imm = 3'b011; end
            OP_JALR:  begin c.jp = 1; c.jr = 1; c.as = 1; c.rw = 1; c.rs = 2'b10; end
            OP_LUI:   begin c.rw = 1; c.rs = 2'b11; c.imm = 3'b100; end
            OP_AUIPC: begin c.asa = 1; c.as = 1; c.rw = 1; c.imm = 3'b100; end
            default:  begin c = '0; c.ill = 1; end
        endcase
        return c;
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: drive, check decode, clock, advance model, check stages.
    task automatic step(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                        input logic f75, input logic stall, input logic flush,
                        input logic z, input logic lt, input logic ltu);
        ctl_t d, ne, nm, nw;
        rst_n = rst; op_d = op; funct3_d = f3; funct7_5_d = f75;
        stall_e = stall; flush_e = flush; zero_e = z; lt_e = lt; ltu_e = ltu;
        d = ref_decode(op, f3, f75);
        #1;
        check("ImmSrc_d", ImmSrc_d, d.imm);
        check("illegal_d", illegal_d, d.ill);
        @(posedge clk);
        if (!rst) begin
            ne = '0; nm = '0; nw = '0;
        end else begin
            nw = mdl_m;
            nm = (stall && !flush) ? '0 : mdl_e;
            ne = flush ? '0 : (stall ? mdl_e : d);
        end
        mdl_e = ne; mdl_m = nm; mdl_w = nw;
        #1;
        check("ALUControl_e", ALUControl_e, mdl_e.alu);
        check("ALUSrc_e", ALUSrc_e, mdl_e.as);
        check("ALUSrcA_e", ALUSrcA_e, mdl_e.asa);
        check("ResultSrc_e", ResultSrc_e, mdl_e.rs);
        check("RegWrite_e", RegWrite_e, mdl_e.rw);
        check("JumpReg_e", JumpReg_e, mdl_e.jr);
        check("PCSrc_e", PCSrc_e, mdl_e.jp | (mdl_e.br & taken(mdl_e.f3, z, lt, ltu)));
        check("RegWrite_m", RegWrite_m, mdl_m.rw);
        check("MemWrite_m", MemWrite_m, mdl_m.mw);
        check("ResultSrc_m", ResultSrc_m, mdl_m.rs);
        check("RegWrite_w", RegWrite_w, mdl_w.rw);
        check("ResultSrc_w", ResultSrc_w, mdl_w.rs);
        check("illegal_w", illegal_w, mdl_w.ill);
        @(negedge clk);
    endtask

    task automatic nop();
        step(1, OP_I, 3'd0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [6:0] legal_ops [9];

    initial begin
        legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        // Reset, then add followed by NOPs.
        step(0, OP_R, 3'd0, 0, 0, 0, 0, 0, 0);
        check("rst_RegWrite_e", RegWrite_e, 0);
        check("rst_RegWrite_w", RegWrite_w, 0);
        step(1, OP_R, 3'd0, 0, 0, 0, 0, 0, 0);
        check("add_alu_e", ALUControl_e, 4'b0000);
        check("add_rw_e", RegWrite_e, 1);
        nop();
        check("add_rw_m", RegWrite_m, 1);
        nop();
        check("add_rw_w", RegWrite_w, 1);
        check("add_rs_w", ResultSrc_w, 2'b00);

        // Branch conditions.
        step(1, OP_BR, 3'd0, 0, 0, 0, 1, 0, 0);
        check("beq_taken", PCSrc_e, 1);
        step(1, OP_BR, 3'd5, 0, 0, 0, 0, 1, 0);
        check("bge_not_taken", PCSrc_e, 0);
        step(1, OP_BR, 3'd6, 0, 0, 0, 0, 0, 1);
        check("bltu_taken", PCSrc_e, 1);
        step(1, OP_BR, 3'd2, 0, 0, 0, 1, 1, 1);
        check("br_f3_010", PCSrc_e, 0);

        // Load followed by a two-cycle stall.
        step(1, OP_LOAD, 3'd2, 0, 0, 0, 0, 0, 0);
        step(1, OP_R, 3'd0, 0, 1, 0, 0, 0, 0);
        check("lw_stall1_rs_e", ResultSrc_e, 2'b01);
        check("lw_stall1_rw_m", RegWrite_m, 0);
        step(1, OP_R, 3'd0, 0, 1, 0, 0, 0, 0);
        check("lw_stall2_rs_e", ResultSrc_e, 2'b01);
        check("lw_stall2_rw_m", RegWrite_m, 0);
        step(1, OP_R, 3'd0, 0, 0, 0, 0, 0, 0);
        check("lw_release_rs_m", ResultSrc_m, 2'b01);

        // jal flushed in the same cycle, then flush together with stall.
        step(1, OP_JAL, 3'd0, 0, 0, 1, 0, 0, 0);
        check("jal_flush_pc", PCSrc_e, 0);
        check("jal_flush_rw", RegWrite_e, 0);
        step(1, OP_JAL, 3'd0, 0, 1, 1, 0, 0, 0);
        check("jal_flush_stall_pc", PCSrc_e, 0);

        // Illegal opcode travels to Writeback.
        step(1, 7'b1111111, 3'd0, 0, 0, 0, 0, 0, 0);
        nop();
        nop();
        check("ill_w", illegal_w, 1);
        check("ill_rw_w", RegWrite_w, 0);

        // Assorted decodes.
        step(1, OP_STORE, 3'd2, 0, 0, 0, 0, 0, 0);
        nop();
        check("sw_mw_m", MemWrite_m, 1);
        step(1, OP_I, 3'd0, 1, 0, 0, 0, 0, 0);
        check("addi_f7_alu", ALUControl_e, 4'b0000);
        step(1, OP_I, 3'd5, 1, 0, 0, 0, 0, 0);
        check("srai_alu", ALUControl_e, 4'b1001);
        step(1, OP_LUI, 3'd0, 0, 0, 0, 0, 0, 0);
        check("lui_rs_e", ResultSrc_e, 2'b11);
        step(1, OP_AUIPC, 3'd0, 0, 0, 0, 0, 0, 0);
        check("auipc_asa", ALUSrcA_e, 1);

        // Mid-stream reset.
        step(1, OP_JAL, 3'd0, 0, 0, 0, 0, 0, 0);
        step(1, OP_LOAD, 3'd0, 0, 0, 0, 0, 0, 0);
        step(0, OP_R, 3'd0, 0, 0, 0, 0, 0, 0);
        check("midrst_rw_e", RegWrite_e, 0);
        check("midrst_pc", PCSrc_e, 0);
        check("midrst_rw_m", RegWrite_m, 0);
        check("midrst_rs_w", ResultSrc_w, 2'b00);

        // Randomized stream.
        for (int i = 0; i < 1500; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
            step(($urandom_range(0, 49) != 0), op, 3'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
